// File: rtl/irq_pending_ctrl_if.sv
// Request/handshake bundle between peripheral request wires, the interrupt
// front-end and the interrupt consumer.
interface irq_pending_ctrl_if;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] mask;
  logic            irq_valid;
  logic [IDW-1:0]  irq_id;
  logic            irq_ack;
  logic            eoi;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] in_service;

  // Consumer/environment side: drives requests, mask and handshake.
  modport master (
    output req, mask, irq_ack, eoi,
    input  irq_valid, irq_id, pending, in_service
  );

  // Front-end side.
  modport slave (
    input  req, mask, irq_ack, eoi,
    output irq_valid, irq_id, pending, in_service
  );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronises four request lines, latches rising edges
// as pending, and presents the highest eligible request above the current
// in-service level on a valid/ack handshake. EOI retires service levels.
module irq_pending_ctrl #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst_n,
  irq_pending_ctrl_if.slave bus
);
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] sync_q [SYNC_STAGES];
  logic [NREQ-1:0] req_d_q;
  logic [NREQ-1:0] pending_q;
  logic [NREQ-1:0] in_service_q;
  logic            irq_valid_q;
  logic [IDW-1:0]  irq_id_q;

  logic [NREQ-1:0] req_s;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] above_thr;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  sel;
  logic [NREQ-1:0] retire_bit;
  logic [NREQ-1:0] in_service_eoi;
  logic            ack_fire;
  logic [NREQ-1:0] ack_bit;

  assign req_s = sync_q[SYNC_STAGES-1];
  assign rise  = req_s & ~req_d_q;

  // Eligibility, selection, EOI retirement and ack decode.
  always_comb begin
    above_thr  = '0;
    sel        = '0;
    retire_bit = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      // Bit i is above the threshold when nothing at or above i is in service.
      above_thr[i] = ~(|(in_service_q >> i));
    end
    eligible = pending_q & ~bus.mask & above_thr;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (eligible[i]) sel = IDW'(i);
      if (in_service_q[i]) begin
        retire_bit    = '0;
        retire_bit[i] = 1'b1;
      end
    end
    in_service_eoi = bus.eoi ? (in_service_q & ~retire_bit) : in_service_q;
    ack_fire       = irq_valid_q & bus.irq_ack;
    ack_bit        = ack_fire ? (NREQ'(1) << irq_id_q) : '0;
  end

  // Synchroniser, edge detect, pending/in-service bookkeeping and handshake FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      req_d_q      <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_valid_q  <= 1'b0;
      irq_id_q     <= '0;
      state_q      <= IDLE;
    end else begin
      sync_q[0] <= bus.req;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      req_d_q <= req_s;
      // A fresh edge wins over the ack clearing the same bit.
      pending_q    <= (pending_q & ~ack_bit) | rise;
      // EOI retires from the old in-service set before the ack adds its bit.
      in_service_q <= in_service_eoi | ack_bit;
      case (state_q)
        IDLE, SERVICE: begin
          if (|eligible) begin
            state_q     <= PRESENT;
            irq_valid_q <= 1'b1;
            irq_id_q    <= sel;
          end else begin
            state_q <= (|in_service_eoi) ? SERVICE : IDLE;
          end
        end
        PRESENT: begin
          if (ack_fire) begin
            state_q     <= SERVICE;
            irq_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          irq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pending    = pending_q;
  assign bus.in_service = in_service_q;
  assign bus.irq_valid  = irq_valid_q;
  assign bus.irq_id     = irq_id_q;

endmodule
